ascii_operand_loader: RTL
=========================

Name: ascii_operand_loader

Overview:
- Upstream stage of the 5-bit ripple adder: turns a serial ASCII character stream into one X/Y operand pair.
- Each operand is two decimal digit characters followed by one terminator character, i.e. 3 characters per operand and 6 per pair.
- It presents X and Y together with a valid/ready handshake, plus format and range error flags.
- The adder's X and Y inputs connect directly to x and y.

Parameters:
- OP_WIDTH, 5, width of each emitted operand; the representable maximum is 2^OP_WIDTH-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- char_data  input  8  ASCII character from the upstream source.
- char_valid  input  1  char_data is valid this cycle.
- char_ready  output  1  loader accepts a character this cycle.
- x  output  OP_WIDTH  first operand.
- y  output  OP_WIDTH  second operand.
- op_valid  output  1  x/y/flags form a complete pair.
- op_ready  input  1  downstream consumes the pair.
- fmt_err  output  1  a non-digit character appeared in a digit position of this pair.
- rng_err  output  1  an operand's decimal value exceeded 2^OP_WIDTH-1.

Behaviour:
- Reset (synchronous, active-high):
  - state goes to X_D1.
  - x, y, op_valid, fmt_err and rng_err all go to 0; char_ready goes to 1.
  - Any partial pair is discarded, including when reset arrives mid-pair or while in PRESENT.
- Character transfer:
  - A character is accepted only on a cycle where char_valid and char_ready are both 1.
  - char_ready is 1 in every state except PRESENT, where it is 0.
  - char_ready is a function of state only (registered); it does not depend on char_valid.
- States, in order: X_D1, X_D2, X_T, Y_D1, Y_D2, Y_T, PRESENT.
  - Each accepted character advances one state.
  - With no accepted character, the state holds.
- Digit handling (X_D1, X_D2, Y_D1, Y_D2):
  - A character in 8'h30..8'h39 contributes (char - 8'h30).
  - Any other character sets fmt_err and contributes 0.
- Terminator states (X_T, Y_T): the character is consumed and its value ignored; no checking.
- Arithmetic:
  - value = d1*10 + d2, computed in 7 bits, range 0..99.
  - If value > 2^OP_WIDTH-1, set rng_err.
  - The operand register takes the low OP_WIDTH bits (e.g. 45 gives 13).
- Output update timing:
  - x updates on acceptance of the X_D2 character.
  - y updates on acceptance of the Y_D2 character.
  - Acceptance of the Y_T character moves to PRESENT; op_valid is 1 on the following cycle.
  - Latency: 1 cycle from Y_T acceptance to op_valid.
- PRESENT:
  - op_valid = 1; x, y, fmt_err and rng_err are held stable.
  - On op_valid & op_ready: next cycle op_valid = 0, state = X_D1, fmt_err and rng_err clear to 0.
  - x and y keep their last values until overwritten.
- Error flags: sticky for the duration of the pair; cleared only at handoff or reset.
- Simultaneous events: reset has priority over any handshake in the same cycle.
- char_valid with char_ready = 0 has no effect; the upstream source must hold the character.

Decomposition:
- Shared package ascii_pkg:
  - constants ASCII_ZERO = 8'h30 and ASCII_NINE = 8'h39.
  - the loader state enum, 3 bits.
  - the CHARS_PER_OPERAND = 3 constant.
- One sub-module, ascii_digit_decode, combinational:
  - input: 8-bit char.
  - outputs: is_digit (1 bit) and digit (4 bits).
  - The same decode is also reusable by the downstream result formatter.

Test Plan:
- Send "12\n07\n" with char_valid held 1 and op_ready = 1 -> op_valid pulses for one cycle; x = 12, y = 7, fmt_err = 0, rng_err = 0.
- Send "31\n31\n" -> x = 31, y = 31, no errors. Then send "00\n00\n" -> x = 0, y = 0; confirms flag clear and state return to X_D1.
- Send "45\n03\n" -> x = 13, y = 3, rng_err = 1, fmt_err = 0. The next pair "01\n02\n" -> rng_err = 0.
- Send "1a\n05\n" -> fmt_err = 1, x = 10, y = 5.
- Backpressure:
  - Complete the pair "09\n10\n" with op_ready = 0 for 5 cycles while char_valid stays 1 with character "7".
  - Required: op_valid = 1, char_ready = 0, x = 9, y = 10 stable; no character consumed.
  - Then op_ready = 1 -> "7" is accepted as X_D1 one cycle after handoff.
- Reset mid-pair: send "2", "3", "\n", "1", assert rst for 1 cycle, then send "04\n06\n" -> all outputs 0 after reset; x = 4, y = 6 with no errors.

Source files
------------

// File: rtl/ascii_pkg.sv
// ascii_pkg
// Shared definitions for the ASCII operand loader and anything else that
// decodes decimal characters (for example the downstream result formatter).
//   ASCII_ZERO / ASCII_NINE : bounds of the decimal digit characters
//   CHARS_PER_OPERAND       : two digits plus one terminator
//   loader_state_e          : loader sequencing states, 3 bits
//   operand_value()         : combines two decimal digits into a 7-bit value
package ascii_pkg;

    localparam logic [7:0] ASCII_ZERO        = 8'h30;
    localparam logic [7:0] ASCII_NINE        = 8'h39;
    localparam int         CHARS_PER_OPERAND = 3;

    typedef enum logic [2:0] {
        X_D1    = 3'd0,
        X_D2    = 3'd1,
        X_T     = 3'd2,
        Y_D1    = 3'd3,
        Y_D2    = 3'd4,
        Y_T     = 3'd5,
        PRESENT = 3'd6
    } loader_state_e;

    // Tens digit times ten plus units digit; at most 99, so 7 bits suffice.
    function automatic logic [6:0] operand_value(input logic [3:0] d1,
                                                 input logic [3:0] d2);
        return ({3'b000, d1} * 7'd10) + {3'b000, d2};
    endfunction

endpackage

// File: rtl/ascii_digit_decode.sv
// ascii_digit_decode
// Purely combinational decode of one ASCII character into a decimal digit.
//   ascii_char : input  8  character to decode
//   is_digit   : output 1  character lies in '0'..'9'
//   digit      : output 4  digit value, 0 when the character is not a digit
module ascii_digit_decode
    import ascii_pkg::*;
(
    input  logic [7:0] ascii_char,
    output logic       is_digit,
    output logic [3:0] digit
);

    logic in_range_s;

    // Range test and digit extraction; non-digits contribute zero.
    always_comb begin
        in_range_s = (ascii_char >= ASCII_ZERO) && (ascii_char <= ASCII_NINE);
        is_digit   = in_range_s;
        if (in_range_s) begin
            digit = ascii_char[3:0];
        end else begin
            digit = 4'd0;
        end
    end

endmodule

// File: rtl/ascii_operand_loader.sv
// ascii_operand_loader
// Collects a serial ASCII stream of the form "DDtDDt" (two decimal digits and
// one terminator per operand) into an X/Y operand pair for the ripple adder.
//   clk, rst   : clock and synchronous active-high reset
//   char_data  : input  8        incoming ASCII character
//   char_valid : input  1        char_data is valid
//   char_ready : output 1        loader accepts a character (low while presenting)
//   x, y       : output OP_WIDTH operands, low OP_WIDTH bits of the decimal value
//   op_valid   : output 1        x/y/flags form a complete pair
//   op_ready   : input  1        downstream consumes the pair
//   fmt_err    : output 1        a non-digit appeared in a digit position
//   rng_err    : output 1        an operand exceeded 2^OP_WIDTH-1
module ascii_operand_loader
    import ascii_pkg::*;
#(
    parameter int OP_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          char_data,
    input  logic                char_valid,
    output logic                char_ready,
    output logic [OP_WIDTH-1:0] x,
    output logic [OP_WIDTH-1:0] y,
    output logic                op_valid,
    input  logic                op_ready,
    output logic                fmt_err,
    output logic                rng_err
);

    // Largest representable operand, sized to the 7-bit decimal value.
    localparam logic [6:0] OP_MAX_V = 7'((1 << OP_WIDTH) - 1);

    loader_state_e       state_r;
    logic                char_ready_r;
    logic                op_valid_r;
    logic                fmt_err_r;
    logic                rng_err_r;
    logic [OP_WIDTH-1:0] x_r;
    logic [OP_WIDTH-1:0] y_r;
    logic [3:0]          d1_r;

    logic                is_digit_s;
    logic [3:0]          digit_s;
    logic [6:0]          value_s;
    logic                accept_s;
    logic                over_s;

    ascii_digit_decode u_decode (
        .ascii_char (char_data),
        .is_digit   (is_digit_s),
        .digit      (digit_s)
    );

    // Handshake and operand arithmetic; value_s is only meaningful in a D2 state.
    always_comb begin
        accept_s = char_valid & char_ready_r;
        value_s  = operand_value(d1_r, digit_s);
        over_s   = (value_s > OP_MAX_V);
    end

    // Loader sequencing, operand capture and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= X_D1;
            char_ready_r <= 1'b1;
            op_valid_r   <= 1'b0;
            fmt_err_r    <= 1'b0;
            rng_err_r    <= 1'b0;
            x_r          <= '0;
            y_r          <= '0;
            d1_r         <= 4'd0;
        end else begin
            case (state_r)
                X_D1: begin
                    if (accept_s) begin
                        d1_r      <= digit_s;
                        fmt_err_r <= fmt_err_r | ~is_digit_s;
                        state_r   <= X_D2;
                    end
                end
                X_D2: begin
                    if (accept_s) begin
                        x_r       <= value_s[OP_WIDTH-1:0];
                        fmt_err_r <= fmt_err_r | ~is_digit_s;
                        rng_err_r <= rng_err_r | over_s;
                        state_r   <= X_T;
                    end
                end
                X_T: begin
                    // Terminator content is deliberately ignored.
                    if (accept_s) begin
                        state_r <= Y_D1;
                    end
                end
                Y_D1: begin
                    if (accept_s) begin
                        d1_r      <= digit_s;
                        fmt_err_r <= fmt_err_r | ~is_digit_s;
                        state_r   <= Y_D2;
                    end
                end
                Y_D2: begin
                    if (accept_s) begin
                        y_r       <= value_s[OP_WIDTH-1:0];
                        fmt_err_r <= fmt_err_r | ~is_digit_s;
                        rng_err_r <= rng_err_r | over_s;
                        state_r   <= Y_T;
                    end
                end
                Y_T: begin
                    // Stop taking characters while the pair is on offer.
                    if (accept_s) begin
                        state_r      <= PRESENT;
                        op_valid_r   <= 1'b1;
                        char_ready_r <= 1'b0;
                    end
                end
                PRESENT: begin
                    // x/y stay as they are after handoff; only flags clear.
                    if (op_valid_r & op_ready) begin
                        state_r      <= X_D1;
                        op_valid_r   <= 1'b0;
                        char_ready_r <= 1'b1;
                        fmt_err_r    <= 1'b0;
                        rng_err_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= X_D1;
                    char_ready_r <= 1'b1;
                    op_valid_r   <= 1'b0;
                    fmt_err_r    <= 1'b0;
                    rng_err_r    <= 1'b0;
                end
            endcase
        end
    end

    assign char_ready = char_ready_r;
    assign op_valid   = op_valid_r;
    assign fmt_err    = fmt_err_r;
    assign rng_err    = rng_err_r;
    assign x          = x_r;
    assign y          = y_r;

endmodule
